vliw_bundle_loader: RTL
=======================

Name: vliw_bundle_loader

Overview:
Upstream feeder for the VLIW processor's instruction memory. It accepts instruction bundles, each tagged with a target bundle address, through a valid/ready handshake and buffers them in a small FIFO. It writes each bundle into instruction memory and zero-fills (NOP) every address skipped between consecutive targets, so imem contents are deterministic. It signals done when the bundle flagged last has been retired, which releases the processor to run.

Parameters:
SLOTS, 8, instruction words per bundle
SLOT_W, 32, bits per instruction word
ADDR_W, 8, bundle address width
IMEM_DEPTH, 64, number of valid bundle addresses (0..IMEM_DEPTH-1)
FIFO_DEPTH, 4, input buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  bundle offered
in_ready  out  1  loader can accept this cycle
in_bundle  in  SLOTS*SLOT_W  bundle; slot 0 in MSBs
in_addr  in  ADDR_W  target bundle address
in_last  in  1  final bundle of the program
restart  in  1  leave DONE and begin a new load
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  write address
imem_wdata  out  SLOTS*SLOT_W  write data
busy  out  1  FIFO non-empty or fill in progress
done  out  1  program load complete (held)
err  out  1  sticky error flag
err_code  out  2  first error: 0 none, 1 non-monotonic address, 2 address out of range

Behaviour:
- Reset (async, rst_n=0): FIFO empty; next_addr=0; state IDLE; imem_we=0; imem_addr=0; imem_wdata=0; busy=0; done=0; err=0; err_code=0; in_ready=0 while rst_n=0. Reset mid-fill aborts immediately, with no further writes.
- Handshake: a transfer occurs on a clk edge with in_valid && in_ready. in_ready = rst_n && !fifo_full && state!=DONE. A push and a pop may happen in the same edge. in_ready does not look ahead to a same-cycle pop, so no push occurs when the FIFO is full.
- All imem outputs are registered. A bundle accepted at edge k drives imem_we at the earliest in cycle k+1 (1-cycle latency when no fill is needed).
- States: IDLE, FILL, WRITE, DONE. The head entry is evaluated every cycle in IDLE, FILL and WRITE.
- head.addr >= IMEM_DEPTH: pop and discard, no write. Set err with err_code=2 if err_code was 0.
- head.addr < next_addr: pop and discard, no write. Set err with err_code=1 if err_code was 0.
- head.addr > next_addr: state FILL. Write zero bundle at next_addr, next_addr+1. One write per cycle; no pop.
- head.addr == next_addr: state WRITE. Write the head bundle, pop, next_addr=head.addr+1.
- If the popped entry (written or discarded) has last=1, go to DONE. Set done=1 on the following edge and hold it.
- Entries behind a last entry cannot exist, because in_ready=0 in DONE.
- FIFO empty and not DONE: state IDLE, imem_we=0.
- DONE: no writes; in_ready=0; done=1. restart=1 clears done, next_addr, err and err_code, and returns to IDLE.
- restart outside DONE is ignored.
- next_addr saturates at IMEM_DEPTH; it never wraps.
- busy = !fifo_empty || state==FILL.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, imem_we=0, done=0. Release rst_n -> in_ready=1 next cycle.
- Single bundle, addr 0, last=1, accepted at edge k -> imem_we=1 in cycle k+1 with addr 0 and matching data. done=1 from edge k+2; in_ready=0.
- Gap fill: addrs 0, 26, 34, 42, 50 (last) -> exactly 51 writes. Addrs 1-25, 27-33, 35-41 and 43-49 carry zero data; the other five carry the supplied bundles. err=0.
- Backpressure: hold in_valid=1 with 4 bundles at addr 10,11,12,13 -> in_ready drops once the FIFO is full during the 10-cycle fill. No bundle is lost or duplicated, and write order is preserved.
- Errors: addr 5, then addr 3, then addr 70 (last) -> the addr-3 and addr-70 bundles are not written. err=1, err_code=1 (the first error is kept). done=1.
- Reset mid-fill: addr 40 accepted; deassert rst_n at the 10th fill write -> imem_we=0 immediately. After re-release, state and next_addr are back to 0, and a new addr-0 bundle is written without fill.

Source files
------------

// File: rtl/vliw_bundle_loader.sv
// VLIW instruction-memory loader: buffers address-tagged bundles in a FIFO,
// writes them to imem in order, and zero-fills every skipped address.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       bundle handshake (in_bundle, in_addr, in_last)
//   restart                 leave DONE and start a new load
//   imem_we/addr/wdata      registered instruction-memory write port
//   busy                    FIFO non-empty or gap fill in progress
//   done                    load complete (held until restart)
//   err/err_code            sticky error, first cause (1 order, 2 range)
module vliw_bundle_loader #(
    parameter int SLOTS      = 8,
    parameter int SLOT_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int IMEM_DEPTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SLOTS*SLOT_W-1:0] in_bundle,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic                    in_last,
    input  logic                    restart,
    output logic                    imem_we,
    output logic [ADDR_W-1:0]       imem_addr,
    output logic [SLOTS*SLOT_W-1:0] imem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code
);

    localparam int BW = SLOTS * SLOT_W;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // One extra bit so next_addr can hold IMEM_DEPTH without wrapping.
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] ONE_A   = (ADDR_W + 1)'(1);

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_ORDER = 2'd1;
    localparam logic [1:0] E_RANGE = 2'd2;

    // ---------------- input FIFO ----------------
    logic [BW-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic              fifo_last_q [FIFO_DEPTH];
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic              fifo_empty, fifo_full;
    logic              push, pop;

    logic [BW-1:0]     head_data;
    logic [ADDR_W:0]   head_addr;
    logic              head_last;

    // ---------------- loader state ----------------
    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   next_addr_q, next_addr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [BW-1:0]     wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic [ADDR_W:0]   head_next;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    // Ready is not lookahead: a full FIFO refuses even if it pops this edge.
    assign in_ready = rst_n && !fifo_full && (state_q != S_DONE);
    assign push     = in_valid && in_ready;

    assign head_data = fifo_data_q[rd_ptr_q[PW-1:0]];
    assign head_addr = {1'b0, fifo_addr_q[rd_ptr_q[PW-1:0]]};
    assign head_last = fifo_last_q[rd_ptr_q[PW-1:0]];

    assign wr_ptr_d = wr_ptr_q + (PW + 1)'(push);
    assign rd_ptr_d = rd_ptr_q + (PW + 1)'(pop);

    // head_addr < IMEM_DEPTH when used, so +1 tops out at IMEM_DEPTH.
    always_comb begin
        head_next = head_addr + ONE_A;
        if (head_next > DEPTH_A) begin
            head_next = DEPTH_A;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q[PW-1:0]] <= in_bundle;
            fifo_addr_q[wr_ptr_q[PW-1:0]] <= in_addr;
            fifo_last_q[wr_ptr_q[PW-1:0]] <= in_last;
        end
    end

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = done_q;
        err_d       = err_q;
        code_d      = code_q;
        pop         = 1'b0;

        unique case (state_q)
            S_DONE: begin
                done_d = 1'b1;
                if (restart) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b0;
                    next_addr_d = '0;
                    err_d       = 1'b0;
                    code_d      = E_NONE;
                end
            end
            S_IDLE, S_FILL, S_WRITE: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                end else if (head_addr >= DEPTH_A) begin
                    pop     = 1'b1;
                    err_d   = 1'b1;
                    state_d = head_last ? S_DONE : S_IDLE;
                    if (code_q == E_NONE) begin
                        code_d = E_RANGE;
                    end
                end else if (head_addr < next_addr_q) begin
                    pop     = 1'b1;
                    err_d   = 1'b1;
                    state_d = head_last ? S_DONE : S_IDLE;
                    if (code_q == E_NONE) begin
                        code_d = E_ORDER;
                    end
                end else if (head_addr > next_addr_q) begin
                    // Zero-fill one skipped address; head stays queued.
                    state_d     = S_FILL;
                    we_d        = 1'b1;
                    waddr_d     = next_addr_q[ADDR_W-1:0];
                    wdata_d     = '0;
                    next_addr_d = next_addr_q + ONE_A;
                end else begin
                    state_d     = head_last ? S_DONE : S_WRITE;
                    pop         = 1'b1;
                    we_d        = 1'b1;
                    waddr_d     = head_addr[ADDR_W-1:0];
                    wdata_d     = head_data;
                    next_addr_d = head_next;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            next_addr_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= E_NONE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign busy       = !fifo_empty || (state_q == S_FILL);
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;

endmodule
